// File: rtl/branch_resolve_if.sv
// Decode-side request, result and redirect signals of the branch resolution unit.
interface branch_resolve_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_pc;
  logic [31:0]      in_imm;
  logic             in_pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [31:0]      out_target;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output in_valid, in_op, in_a, in_b, in_pc, in_imm, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_target, redirect, redirect_pc,
           mispredict_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_pc, in_imm, in_pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_target, redirect, redirect_pc,
           mispredict_count
  );
endinterface

// File: rtl/branch_resolve.sv
// Two-stage branch resolution: S1 holds operands, S2 holds the resolved result;
// a mispredict leaving S2 redirects fetch and squashes the younger entry in S1.
module branch_resolve #(
  parameter int CNT_W = 16
) (
  input logic             clock,
  input logic             reset_n,
  branch_resolve_if.slave bus
);

  typedef enum logic [1:0] {
    OP_BEQ = 2'd0,
    OP_BNE = 2'd1,
    OP_BLT = 2'd2,
    OP_JMP = 2'd3
  } op_e;

  logic        s1_valid;
  op_e         s1_op;
  logic [31:0] s1_a, s1_b, s1_pc, s1_imm;
  logic        s1_pred;

  logic        s2_valid, s2_taken, s2_mis;
  logic [31:0] s2_target, s2_next_pc;

  logic [CNT_W-1:0] cnt;

  logic        fire, squash, s2_free, s1_adv, rdy, accept;
  logic        eq, lt, taken;
  logic [31:0] target, fallthrough;

  always_comb begin
    fire    = s2_valid & bus.out_ready;
    squash  = fire & s2_mis;
    s2_free = !s2_valid | bus.out_ready;
    // The squashed S1 entry is on the wrong path, so it must not move into S2.
    s1_adv  = s1_valid & s2_free & !squash;
    rdy     = (!s1_valid | s1_adv) & !squash;
    accept  = bus.in_valid & rdy;
  end

  always_comb begin
    eq          = &(s1_a ~^ s1_b);
    lt          = $signed(s1_a) < $signed(s1_b);
    fallthrough = s1_pc + 32'd1;
    target      = s1_pc + 32'd1 + s1_imm;
    taken       = 1'b1;
    unique case (s1_op)
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLT:  taken = lt;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_BEQ;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_pc    <= '0;
      s1_imm   <= '0;
      s1_pred  <= 1'b0;
    end else if (squash) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op_e'(bus.in_op);
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
      s1_pc    <= bus.in_pc;
      s1_imm   <= bus.in_imm;
      s1_pred  <= bus.in_pred_taken;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 fields only load on advance so they stay frozen under backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid   <= 1'b0;
      s2_taken   <= 1'b0;
      s2_mis     <= 1'b0;
      s2_target  <= '0;
      s2_next_pc <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_adv;
      if (s1_adv) begin
        s2_taken   <= taken;
        s2_mis     <= taken ^ s1_pred;
        s2_target  <= target;
        s2_next_pc <= taken ? target : fallthrough;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (squash && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready         = rdy;
  assign bus.out_valid        = s2_valid;
  assign bus.out_taken        = s2_taken;
  assign bus.out_target       = s2_target;
  assign bus.redirect         = squash;
  assign bus.redirect_pc      = s2_next_pc;
  assign bus.mispredict_count = cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: accepted branches queue their expected
// result; a negedge monitor pops and checks every result handshake.
module tb_branch_resolve;
  localparam int CNT_W = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  branch_resolve_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve #(.CNT_W(CNT_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0, errors = 0;
  int unsigned model_cnt = 0;
  int unsigned accepts = 0, fires = 0, squashed = 0;
  logic        force_ready = 1'b1, rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: resolution rules applied directly to one branch.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    exp_t e;
    bit   t;
    case (op)
      2'd0:    t = (a == b);
      2'd1:    t = (a != b);
      2'd2:    t = (int'(a) < int'(b));
      default: t = 1'b1;
    endcase
    e.taken   = t;
    e.target  = pc + imm + 32'd1;
    e.next_pc = t ? e.target : pc + 32'd1;
    e.mis     = (t != pred);
    return e;
  endfunction

  always @(posedge clock) begin
    #1;
    bus.out_ready = rand_ready ? ($urandom_range(3) != 0) : force_ready;
  end

  // Monitor / scoreboard
  logic        mfire, mexp_red, held_prev = 1'b0, h_taken;
  logic [31:0] h_target, h_rpc;
  exp_t        me;

  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      model_cnt = 0;
      held_prev = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_taken", bus.out_taken, 0);
      chk("rst_out_target", bus.out_target, 0);
      chk("rst_redirect", bus.redirect, 0);
      chk("rst_redirect_pc", bus.redirect_pc, 0);
      chk("rst_count", bus.mispredict_count, 0);
      chk("rst_in_ready", bus.in_ready, 1);
    end else begin
      mfire    = bus.out_valid & bus.out_ready;
      mexp_red = mfire && (q.size() > 0) && q[0].mis;
      if (held_prev) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_taken", bus.out_taken, h_taken);
        chk("stall_target", bus.out_target, h_target);
        chk("stall_redirect_pc", bus.redirect_pc, h_rpc);
      end
      held_prev = bus.out_valid & !bus.out_ready;
      h_taken   = bus.out_taken;
      h_target  = bus.out_target;
      h_rpc     = bus.redirect_pc;

      chk("count", bus.mispredict_count, (CNT_W)'(model_cnt));
      chk("out_without_entry", bus.out_valid && (q.size() == 0), 0);
      chk("redirect", bus.redirect, mexp_red);
      chk("in_ready_full", bus.in_ready && (q.size() >= 2) && !mfire, 0);
      if (mexp_red) chk("in_ready_squash", bus.in_ready, 0);

      if (mfire && q.size() > 0) begin
        me = q.pop_front();
        fires++;
        chk("out_taken", bus.out_taken, me.taken);
        chk("out_target", bus.out_target, me.target);
        chk("redirect_pc", bus.redirect_pc, me.next_pc);
        if (me.mis) begin
          if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
          if (q.size() > 0) begin
            void'(q.pop_front());
            squashed++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_op, bus.in_a, bus.in_b, bus.in_pc, bus.in_imm, bus.in_pred_taken));
        accepts++;
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    int unsigned n = 0;
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_a = a; bus.in_b = b;
    bus.in_pc = pc; bus.in_imm = imm; bus.in_pred_taken = pred;
    @(negedge clock);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (n >= 100) chk("accept_timeout", bus.in_ready, 1);
  endtask

  task automatic idle();
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input logic e_taken, input logic [31:0] e_target,
                          input logic e_red, input logic [31:0] e_rpc);
    drive(op, a, b, pc, imm, pred);
    idle();
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_latency"}, bus.out_valid, 1);
    chk({tag, "_taken"}, bus.out_taken, e_taken);
    chk({tag, "_target"}, bus.out_target, e_target);
    chk({tag, "_redirect"}, bus.redirect, e_red);
    chk({tag, "_redirect_pc"}, bus.redirect_pc, e_rpc);
  endtask

  task automatic wait_drain(input string tag, input int unsigned bound);
    int unsigned n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk({tag, "_drain"}, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, a0, f0, s0;
    logic [31:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
    bus.in_pc = '0; bus.in_imm = '0; bus.in_pred_taken = 1'b0;

    // Reset with random inputs toggling
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      bus.in_valid = 1'($urandom); bus.in_op = 2'($urandom);
      bus.in_a = $urandom; bus.in_b = $urandom; bus.in_pc = $urandom;
      bus.in_imm = $urandom; bus.in_pred_taken = 1'($urandom);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);

    directed("beq", 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 32'h10, 1'b0,
             1'b1, 32'h111, 1'b1, 32'h111);
    @(negedge clock);
    chk("beq_count", bus.mispredict_count, 1);
    directed("blt_neg", 2'd2, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0, 1'b1,
             1'b1, 32'h1F1, 1'b0, 32'h1F1);
    directed("blt_pos", 2'd2, 32'h1, 32'hFFFFFFFF, 32'h200, 32'hFFFFFFF0, 1'b1,
             1'b0, 32'h1F1, 1'b1, 32'h201);
    directed("jmp_wrap", 2'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1,
             1'b1, 32'h0, 1'b0, 32'h0);
    directed("bne_wrap", 2'd1, 32'h1234, 32'h1234, 32'hFFFFFFFF, 32'h5, 1'b0,
             1'b0, 32'h5, 1'b0, 32'h0);
    wait_drain("directed", 10);

    // Backpressure: three offered over five stalled cycles
    force_ready = 1'b0;
    acc = 0;
    f0 = fires;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      bus.in_valid = (acc < 3);
      bus.in_op = 2'd3; bus.in_pred_taken = 1'b1;
      bus.in_pc = 32'h1000 + 32'(acc * 16); bus.in_imm = 32'(acc);
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) acc++;
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    idle();
    force_ready = 1'b1;
    wait_drain("bp", 20);
    chk("bp_results", fires - f0, 2);

    // Squash: first mispredicts, second must vanish
    a0 = accepts; f0 = fires; s0 = squashed;
    drive(2'd3, 32'h0, 32'h0, 32'h300, 32'h40, 1'b0);
    drive(2'd0, 32'h7, 32'h7, 32'h400, 32'h8, 1'b1);
    idle();
    repeat (6) @(negedge clock);
    chk("sq_accepted", accepts - a0, 2);
    chk("sq_results", fires - f0, 1);
    chk("sq_squashed", squashed - s0, 1);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        idle();
      end else begin
        ra = $urandom;
        case ($urandom_range(3))
          0: rb = ra;
          1: rb = 32'($signed(ra) + $signed(32'($urandom_range(2))) - 1);
          default: rb = $urandom;
        endcase
        drive(2'($urandom), ra, rb, $urandom, ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(64)),
              1'($urandom));
      end
    end
    idle();
    rand_ready = 1'b0;
    force_ready = 1'b1;
    wait_drain("random", 50);

    // Counter saturation
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(2'd3, 32'h0, 32'h0, 32'(i), 32'h20, 1'b0);
      idle();
    end
    wait_drain("sat", 10);
    chk("sat_count", bus.mispredict_count, {CNT_W{1'b1}});

    // Reset mid-operation with a full, stalled pipe
    force_ready = 1'b0;
    drive(2'd3, 32'h0, 32'h0, 32'h500, 32'h1, 1'b0);
    drive(2'd3, 32'h0, 32'h0, 32'h600, 32'h1, 1'b0);
    idle();
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_redirect", bus.redirect, 0);
    @(posedge clock); #1;
    force_ready = 1'b1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrst_in_ready", bus.in_ready, 1);
    repeat (5) @(negedge clock);
    chk("midrst_count", bus.mispredict_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
